// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM state
// encoding and small op-decoding helpers.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MADDU = 3'b101;
  localparam logic [2:0] OP_MSUB  = 3'b110;
  localparam logic [2:0] OP_MSUBU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Even op codes are the signed variants.
  function automatic logic is_signed(input logic [2:0] op);
    return ~op[0];
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // MADD/MADDU/MSUB/MSUBU accumulate into {HI,LO}; op[1] selects subtract.
  function automatic logic is_acc(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring divider datapath on unsigned magnitudes, one quotient bit per
// step. The next-step values are exported so the caller can commit the final
// quotient/remainder on the same edge as the last iteration.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] q_next,
  output logic [WIDTH-1:0] r_next
);

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             fits;

  // Trial subtraction: shift the next dividend bit into the partial remainder
  // and keep the difference only if it did not go negative.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, dvsr};
    fits    = ~diff[WIDTH];
    r_next  = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    q_next  = {quo[WIDTH-2:0], fits};
  end

  // Partial remainder / quotient shift registers; the dividend is shifted out
  // of the quotient register as quotient bits are shifted in.
  always_ff @(posedge clk) begin
    if (load) begin
      rem  <= '0;
      quo  <= dividend;
      dvsr <= divisor;
    end else if (step) begin
      rem  <= r_next;
      quo  <= q_next;
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO registers. Operates
// on magnitudes, fixes signs on the final cycle and writes {HI,LO} on the
// same edge the last iteration completes.
module hilo_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             cancel_i,
  input  logic             wr_hi_i,
  input  logic             wr_lo_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div0_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         op_q;
  logic               neg_res;
  logic               neg_rem;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] prod;

  logic               start_ok;
  logic               div0_start;
  logic               last;
  logic               sgn_in;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   q_next;
  logic [WIDTH-1:0]   r_next;
  logic [2*WIDTH-1:0] prod_step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [2*WIDTH-1:0] result;

  // Launch decode and operand magnitudes. Negating MIN yields 2^(WIDTH-1),
  // which is the correct unsigned magnitude.
  always_comb begin
    start_ok   = start_i && (state != ST_CALC);
    div0_start = start_ok && is_div(op_i) && (opb_i == '0);
    last       = (state == ST_CALC) && (cnt == LAST);
    sgn_in     = is_signed(op_i);
    mag_a      = (sgn_in && opa_i[WIDTH-1]) ? -opa_i : opa_i;
    mag_b      = (sgn_in && opb_i[WIDTH-1]) ? -opb_i : opb_i;
  end

  // Final result: the last multiply/divide step is folded in combinationally,
  // then signs are fixed and accumulation uses HI/LO as they stand now.
  always_comb begin
    prod_step = prod + (mplier[0] ? mcand : '0);
    prod_fix  = neg_res ? -prod_step : prod_step;
    acc       = {hi_o, lo_o};
    if (is_acc(op_q))
      mul_res = op_q[1] ? (acc - prod_fix) : (acc + prod_fix);
    else
      mul_res = prod_fix;
    quo_fix   = neg_res ? -q_next : q_next;
    rem_fix   = neg_rem ? -r_next : r_next;
    result    = is_div(op_q) ? {rem_fix, quo_fix} : mul_res;
  end

  div_iter #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk      (clk),
    .load     (start_ok),
    .step     (state == ST_CALC),
    .dividend (mag_a),
    .divisor  (mag_b),
    .q_next   (q_next),
    .r_next   (r_next)
  );

  // Operand latch and shift-add multiply datapath (no reset needed).
  always_ff @(posedge clk) begin
    if (start_ok) begin
      op_q    <= op_i;
      neg_res <= sgn_in && (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
      neg_rem <= sgn_in && opa_i[WIDTH-1];
      mcand   <= {{WIDTH{1'b0}}, mag_a};
      mplier  <= mag_b;
      prod    <= '0;
    end else if (state == ST_CALC) begin
      prod    <= prod_step;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
    end
  end

  // Control FSM with registered status outputs and HI/LO writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      div0_o <= 1'b0;
      hi_o   <= '0;
      lo_o   <= '0;
    end else begin
      done_o <= 1'b0;
      div0_o <= 1'b0;
      if (cancel_i) begin
        state  <= ST_IDLE;
        busy_o <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (wr_hi_i) hi_o <= wdata_i;
            if (wr_lo_i) lo_o <= wdata_i;
            if (div0_start) begin
              state  <= ST_DONE;
              done_o <= 1'b1;
              div0_o <= 1'b1;
            end else if (start_ok) begin
              state  <= ST_CALC;
              busy_o <= 1'b1;
              cnt    <= '0;
            end else begin
              state  <= ST_IDLE;
            end
          end
          ST_CALC: begin
            cnt <= cnt + CNT_W'(1);
            if (last) begin
              {hi_o, lo_o} <= result;
              state        <= ST_DONE;
              busy_o       <= 1'b0;
              done_o       <= 1'b1;
            end
          end
          default: begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed and randomized bench for hilo_muldiv at WIDTH = 32, checked against
// a plain-arithmetic reference model of HI/LO.
module tb_hilo_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_i = 1'b0;
  logic [2:0]   op_i = 3'b000;
  logic [W-1:0] opa_i = '0;
  logic [W-1:0] opb_i = '0;
  logic         cancel_i = 1'b0;
  logic         wr_hi_i = 1'b0;
  logic         wr_lo_i = 1'b0;
  logic [W-1:0] wdata_i = '0;
  logic         busy_o;
  logic         done_o;
  logic         div0_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic         m_div0 = 1'b0;

  hilo_muldiv #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .op_i     (op_i),
    .opa_i    (opa_i),
    .opb_i    (opb_i),
    .cancel_i (cancel_i),
    .wr_hi_i  (wr_hi_i),
    .wr_lo_i  (wr_lo_i),
    .wdata_i  (wdata_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .div0_o   (div0_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: MIPS HI/LO semantics via 64-bit integer arithmetic.
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p, acc;
    bit          sgn;
    sgn    = (op[0] == 1'b0);
    sa     = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb     = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    m_div0 = 1'b0;
    if (op == 3'b010 || op == 3'b011) begin
      if (b == 0) begin
        m_div0 = 1'b1;
      end else begin
        q    = sa / sb;
        r    = sa % sb;
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
    end else begin
      p   = sa * sb;
      acc = {m_hi, m_lo};
      if (op[2]) p = op[1] ? acc - p : acc + p;
      {m_hi, m_lo} = p;
    end
  endtask

  task automatic mt(input bit hi_sel, input logic [W-1:0] d);
    wr_hi_i = hi_sel;
    wr_lo_i = ~hi_sel;
    wdata_i = d;
    tick();
    wr_hi_i = 1'b0;
    wr_lo_i = 1'b0;
    if (hi_sel) m_hi = d; else m_lo = d;
  endtask

  // Launch one op, scramble inputs while it runs, and check timing and HI/LO.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    int n;
    int bc;
    logic [W-1:0] hi0, lo0;
    hi0 = m_hi;
    lo0 = m_lo;
    model(op, a, b);
    start_i = 1'b1;
    op_i    = op;
    opa_i   = a;
    opb_i   = b;
    tick();
    start_i = 1'b0;
    if (m_div0) begin
      check({tag, ".div0_done"}, {63'b0, done_o}, 64'd1);
      check({tag, ".div0_flag"}, {63'b0, div0_o}, 64'd1);
      check({tag, ".div0_busy"}, {63'b0, busy_o}, 64'd0);
      check({tag, ".div0_hilo"}, {hi_o, lo_o}, {hi0, lo0});
    end else begin
      n  = 0;
      bc = 0;
      while (!done_o && n < 100) begin
        if (busy_o) bc++;
        op_i    = 3'($urandom);
        opa_i   = $urandom;
        opb_i   = $urandom;
        start_i = busy_o & $urandom_range(0, 1);
        wr_hi_i = busy_o & $urandom_range(0, 1);
        wdata_i = $urandom;
        tick();
        n++;
      end
      start_i = 1'b0;
      wr_hi_i = 1'b0;
      check({tag, ".latency"}, 64'(n + 1), 64'(W + 1));
      check({tag, ".busy_cycles"}, 64'(bc), 64'(W));
      check({tag, ".busy_at_done"}, {63'b0, busy_o}, 64'd0);
      check({tag, ".div0_clear"}, {63'b0, div0_o}, 64'd0);
      check({tag, ".hilo"}, {hi_o, lo_o}, {m_hi, m_lo});
    end
  endtask

  initial begin
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;
    logic [W-1:0] hs, ls;

    // Reset state
    #2;
    check("reset.hi", {32'b0, hi_o}, 64'd0);
    check("reset.lo", {32'b0, lo_o}, 64'd0);
    check("reset.busy", {63'b0, busy_o}, 64'd0);
    check("reset.done", {63'b0, done_o}, 64'd0);
    check("reset.div0", {63'b0, div0_o}, 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Signed and unsigned multiply, then multiply-subtract back to zero
    do_op("mult", 3'b000, 32'hFFFFFFFB, 32'd6);
    check("mult.const", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFE2);
    do_op("multu", 3'b001, 32'hFFFFFFFB, 32'd6);
    check("multu.const", {hi_o, lo_o}, 64'h00000005_FFFFFFE2);
    do_op("msubu", 3'b111, 32'hFFFFFFFB, 32'd6);
    check("msubu.const", {hi_o, lo_o}, 64'h0);

    // Divides including MIN / -1
    do_op("div", 3'b010, 32'hFFFFFFF9, 32'd2);
    check("div.const", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFD);
    do_op("divu", 3'b011, 32'd7, 32'd2);
    check("divu.const", {hi_o, lo_o}, 64'h00000001_00000003);
    do_op("divmin", 3'b010, 32'h80000000, 32'hFFFFFFFF);
    check("divmin.const", {hi_o, lo_o}, 64'h00000000_80000000);

    // Accumulate over MT-written HI/LO
    tick();
    mt(1'b0, 32'h10);
    mt(1'b1, 32'h0);
    do_op("madd", 3'b100, 32'd3, 32'd4);
    check("madd.const", {hi_o, lo_o}, 64'h00000000_0000001C);
    mt(1'b0, 32'h0);
    mt(1'b1, 32'h0);
    do_op("msub", 3'b110, 32'd1, 32'd1);
    check("msub.const", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFF);

    // Divide by zero leaves HI/LO alone
    mt(1'b1, 32'h11);
    mt(1'b0, 32'h22);
    do_op("divz", 3'b011, 32'd5, 32'd0);
    check("divz.const", {hi_o, lo_o}, 64'h00000011_00000022);
    tick();
    check("divz.after_done", {63'b0, done_o}, 64'd0);

    // Cancel beats start in the same cycle
    start_i = 1'b1; op_i = 3'b000; opa_i = 32'd3; opb_i = 32'd3; cancel_i = 1'b1;
    tick();
    start_i = 1'b0; cancel_i = 1'b0;
    check("cancel_start.busy", {63'b0, busy_o}, 64'd0);

    // Cancel on CALC cycle 10
    hs = hi_o; ls = lo_o;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    check("cancel.busy_in_calc", {63'b0, busy_o}, 64'd1);
    cancel_i = 1'b1;
    tick();
    cancel_i = 1'b0;
    check("cancel.busy", {63'b0, busy_o}, 64'd0);
    check("cancel.done", {63'b0, done_o}, 64'd0);
    for (int i = 0; i < 30; i++) begin
      if (done_o) check("cancel.late_done", {63'b0, done_o}, 64'd0);
      tick();
    end
    check("cancel.hilo", {hi_o, lo_o}, {hs, ls});
    do_op("mult_after_cancel", 3'b000, 32'd3, 32'd3);
    check("mult_after_cancel.lo", {32'b0, lo_o}, 64'd9);

    // Reset in the middle of CALC
    start_i = 1'b1; op_i = 3'b001; opa_i = 32'd1234; opb_i = 32'd77;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    #1;
    check("rst_mid.hilo", {hi_o, lo_o}, 64'd0);
    check("rst_mid.busy", {63'b0, busy_o}, 64'd0);
    m_hi = '0; m_lo = '0;
    tick();
    rst = 1'b0;
    tick();

    // Randomized ops against the model, back to back from the DONE cycle
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) mt($urandom_range(0, 1) == 1, $urandom);
      rop = 3'($urandom);
      case ($urandom_range(0, 4))
        0:       begin ra = 32'h80000000; rb = $urandom_range(0, 1) ? 32'hFFFFFFFF : $urandom; end
        1:       begin ra = $urandom; rb = 32'($urandom_range(0, 3)); end
        2:       begin ra = $urandom_range(0, 100); rb = $urandom_range(0, 100); end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      do_op("rand", rop, ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog simulation did not finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core. It sits beside the EX stage and receives operands and an op code from the pipeline. It computes signed or unsigned multiply, multiply-accumulate/subtract, and divide over a parametrised data width, then writes the double-width result into HI/LO. While it computes, it holds the pipeline stalled through `busy_o`.

## Interface
Parameters:
- `WIDTH`, default 32: operand width and width of HI and of LO.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous and active-high.
- `start_i` in 1: launch the operation given by `op_i` on `opa_i`/`opb_i`.
- `op_i` in 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU.
- `opa_i` in WIDTH: multiplicand or dividend.
- `opb_i` in WIDTH: multiplier or divisor.
- `cancel_i` in 1: pipeline flush; aborts any operation in flight.
- `wr_hi_i` in 1: MTHI write strobe.
- `wr_lo_i` in 1: MTLO write strobe.
- `wdata_i` in WIDTH: data for MTHI/MTLO.
- `busy_o` out 1: operation in progress; the pipeline stalls on it.
- `done_o` out 1: one-cycle pulse; HI/LO already hold the new result in this cycle.
- `div0_o` out 1: qualifies `done_o`; the divide had a zero divisor.
- `hi_o` out WIDTH: HI register.
- `lo_o` out WIDTH: LO register.

## Operation
- States:
  - IDLE, CALC and DONE.
  - IDLE --start--> CALC.
  - CALC --WIDTH iterations--> DONE.
  - DONE --start--> CALC, otherwise DONE --> IDLE.
- Operands are latched at the start edge. Later changes on `opa_i`/`opb_i`/`op_i` have no effect.
- Signed ops work on magnitudes and fix the sign at the end.
  - Product is negative iff the operand signs differ.
  - Quotient is negative iff the operand signs differ.
  - Remainder takes the sign of the dividend.
- Multiply is radix-2 shift-add, one bit per cycle, producing a 2·WIDTH product.
  - MULT/MULTU: {HI,LO} = product.
  - MADD/MADDU: {HI,LO} = {HI,LO} + product.
  - MSUB/MSUBU: {HI,LO} = {HI,LO} − product.
  - All results wrap modulo 2^(2·WIDTH).
- Accumulate ops read HI/LO at the result-write edge, so an MTHI/MTLO issued in the start cycle is included.
- Divide is restoring, one quotient bit per cycle. Result: LO = quotient, HI = remainder.
- Signed MIN ÷ −1 gives LO = MIN, HI = 0.
- Divisor of zero (DIV/DIVU, detected at start):
  - CALC is skipped and the next state is DONE.
  - HI/LO are unchanged.
  - `done_o` = 1 and `div0_o` = 1.
- MTHI/MTLO:
  - Applied at the clock edge in IDLE or DONE.
  - Ignored in CALC; the stall guarantees software never issues them there.
- `cancel_i`:
  - In any state, the next state is IDLE with HI/LO unchanged and no `done_o`.
  - Cancel beats start in the same cycle.
  - Cancel beats the result write on the last CALC cycle.
- `start_i` is ignored while in CALC.

## Timing
- Reset values: state IDLE, `hi_o` = 0, `lo_o` = 0, `busy_o` = 0, `done_o` = 0, `div0_o` = 0.
- Reset mid-operation discards all work.
- Start sampled at edge k:
  - `busy_o` is high for cycles k+1 … k+WIDTH.
  - HI/LO are written at the end of cycle k+WIDTH.
  - `done_o` is high in cycle k+WIDTH+1.
  - Latency is WIDTH+1 cycles.
- Divide-by-zero start at edge k: `done_o` and `div0_o` are high in cycle k+1, and `busy_o` never rises.
- Back-to-back: a start in the DONE cycle enters CALC at the next edge with no idle bubble.
- `busy_o`, `done_o`, `div0_o`, `hi_o` and `lo_o` are all register outputs. There is no combinational path from inputs.

## Structure
- Shared package `muldiv_pkg` holds:
  - the op_i codes (OP_MULT … OP_MSUBU);
  - the state encoding (ST_IDLE, ST_CALC, ST_DONE);
  - helper functions `is_signed(op)`, `is_div(op)` and `is_acc(op)`.
- Sub-module `div_iter`: the restoring-divide datapath.
  - Holds the partial remainder and quotient shift registers.
  - Has a `step` enable and magnitude inputs.
  - Sign fix-up and the FSM stay in the top module.
- The iteration counter is $clog2(WIDTH)+1 bits.

## Test plan
Scenarios use WIDTH = 32.
- MULT 0xFFFFFFFB × 6 → `done_o` 33 cycles after start; HI = 0xFFFFFFFF, LO = 0xFFFFFFE2; `busy_o` high exactly 32 cycles.
- MULTU 0xFFFFFFFB × 6 → HI = 0x00000005, LO = 0xFFFFFFE2. Then MSUBU with the same operands → HI = 0, LO = 0.
- DIV −7 ÷ 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 7 ÷ 2 → LO = 3, HI = 1. DIV 0x80000000 ÷ −1 → LO = 0x80000000, HI = 0.
- MTLO 0x10 and MTHI 0, then MADD 3 × 4 → HI = 0, LO = 0x1C. From HI/LO = 0, MSUB 1 × 1 → HI = 0xFFFFFFFF, LO = 0xFFFFFFFF.
- DIVU 5 ÷ 0 with HI/LO = 0x11/0x22 → `done_o` and `div0_o` high one cycle after start; HI/LO stay 0x11/0x22.
- MULT 3 × 3 with `cancel_i` on cycle 10 of CALC → IDLE next cycle, no `done_o`, HI/LO unchanged. A new MULT 3 × 3 right after → LO = 9. Asserting `rst` mid-CALC clears HI/LO to 0 immediately.
